// File: rtl/padded_frame_source.sv
// Streams one square 8-bit frame from a synchronous RAM as a zero-padded raster.
// Reads are issued against FIFO credits, so the 1-cycle RAM latency never overflows the FIFO.
module padded_frame_source #(
    parameter int IMG_WIDTH = 128,
    parameter int ADDR_W    = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rd_data,
    output logic              valid_out,
    input  logic              ready_in,
    output logic [7:0]        data_out,
    output logic              last_out
);
    localparam int PAD_W = IMG_WIDTH + 2;
    localparam int CW    = $clog2(PAD_W);
    localparam logic [CW-1:0] LAST_C = CW'(PAD_W - 1);
    localparam logic [CW-1:0] IMG_C  = CW'(IMG_WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     row_q, row_d, col_q, col_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              tag_vld_q, tag_pad_q, tag_last_q;
    logic [7:0]        fifo_data_q [0:2];
    logic              fifo_last_q [0:2];
    logic [1:0]        wr_ptr_q, rd_ptr_q, cnt_q;

    logic issue, interior, pos_last, push, pop;
    logic [7:0] wdata;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign interior = (row_q != '0) && (row_q <= IMG_C) && (col_q != '0) && (col_q <= IMG_C);
    assign pos_last = (row_q == LAST_C) && (col_q == LAST_C);
    // Credit check uses registered state only, keeping ready_in off the read path.
    assign issue    = (state_q == S_RUN) && (({1'b0, cnt_q} + {2'b00, tag_vld_q}) < 3'd3);

    assign mem_rd_en = issue && interior;
    assign mem_addr  = addr_q;
    assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done      = (state_q == S_DONE);

    assign valid_out = (cnt_q != 2'd0);
    assign data_out  = fifo_data_q[rd_ptr_q];
    assign last_out  = valid_out && fifo_last_q[rd_ptr_q];

    assign push  = tag_vld_q;
    assign pop   = valid_out && ready_in;
    assign wdata = tag_pad_q ? 8'h00 : mem_rd_data;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        addr_d  = addr_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    row_d   = '0;
                    col_d   = '0;
                    addr_d  = '0;
                end
            end
            S_RUN: begin
                if (issue) begin
                    if (interior) addr_d = addr_q + 1'b1;
                    if (col_q == LAST_C) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                    if (pos_last) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pop && last_out) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            row_q      <= '0;
            col_q      <= '0;
            addr_q     <= '0;
            tag_vld_q  <= 1'b0;
            tag_pad_q  <= 1'b0;
            tag_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            addr_q     <= addr_d;
            tag_vld_q  <= issue;
            tag_pad_q  <= !interior;
            tag_last_q <= pos_last;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            cnt_q    <= 2'd0;
            for (int i = 0; i < 3; i++) begin
                fifo_data_q[i] <= 8'h00;
                fifo_last_q[i] <= 1'b0;
            end
        end else begin
            if (push) begin
                fifo_data_q[wr_ptr_q] <= wdata;
                fifo_last_q[wr_ptr_q] <= tag_last_q;
                wr_ptr_q              <= ptr_inc(wr_ptr_q);
            end
            if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end
endmodule

// File: tb/tb_padded_frame_source.sv
// Bench for padded_frame_source: small 4x4 frame under varied backpressure, plus one default-size frame.
module tb_padded_frame_source;
    localparam int W  = 4;
    localparam int PW = W + 2;
    localparam int NB = PW * PW;

    logic       clk = 0, rst = 1, start = 0, ready = 0;
    logic       busy, done, mem_rd_en, valid_out, last_out;
    logic [3:0] mem_addr;
    logic [7:0] mem_rd_data, data_out;

    logic        b_start = 0;
    logic        b_busy, b_done, b_rd_en, b_valid, b_last;
    logic [13:0] b_addr;
    logic [7:0]  b_rd_data, b_data;

    int total = 0, bad = 0;
    logic [7:0] mem [0:15];
    logic [7:0] exp_d [0:NB-1];
    logic [7:0] got_d [$];
    logic       got_l [$];
    int         rd_q  [$];

    always #5 clk = ~clk;

    padded_frame_source #(.IMG_WIDTH(W), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .valid_out(valid_out), .ready_in(ready), .data_out(data_out), .last_out(last_out));

    padded_frame_source big (
        .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
        .mem_rd_en(b_rd_en), .mem_addr(b_addr), .mem_rd_data(b_rd_data),
        .valid_out(b_valid), .ready_in(1'b1), .data_out(b_data), .last_out(b_last));

    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
        if (b_rd_en)   b_rd_data   <= b_addr[7:0] ^ 8'h5A;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference raster: interior (r,c) maps to pixel (r-1)*W+(c-1), every border position is zero.
    task automatic build_expected();
        for (int r = 0; r < PW; r++)
            for (int c = 0; c < PW; c++)
                exp_d[r*PW+c] = (r >= 1 && r <= W && c >= 1 && c <= W) ? mem[(r-1)*W+(c-1)] : 8'h00;
    endtask

    // mode 0: ready high, 1: ready random, 2: ready low for the first 10 cycles
    task automatic run_frame(input int mode, input bit stray);
        int cyc, first_v, last_acc, done_cyc, stall_bad;
        bit stalled;
        logic [7:0] hd;
        logic hl;
        got_d.delete(); got_l.delete(); rd_q.delete();
        first_v = -1; last_acc = -1; done_cyc = -1; stall_bad = 0; stalled = 0;
        hd = 0; hl = 0;
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
        ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        cyc = 0;
        while (cyc < 400) begin
            @(negedge clk);
            if (cyc == 0) chk("busy_after_start", busy, 1);
            if (mem_rd_en) rd_q.push_back(int'(mem_addr));
            if (valid_out && first_v < 0) first_v = cyc;
            if (stalled && (!valid_out || data_out !== hd || last_out !== hl)) stall_bad++;
            if (mode == 2 && cyc < 10 && valid_out && data_out !== 8'h00) stall_bad++;
            stalled = valid_out && !ready;
            hd = data_out;
            hl = last_out;
            if (valid_out && ready) begin
                got_d.push_back(data_out);
                got_l.push_back(last_out);
                last_acc = cyc;
            end
            if (done) begin
                done_cyc = cyc;
                chk("busy_low_at_done", busy, 0);
                break;
            end
            @(posedge clk); #1;
            cyc++;
            case (mode)
                0:       ready = 1'b1;
                1:       ready = 1'($urandom_range(0, 1));
                default: ready = (cyc >= 10);
            endcase
            start = stray && cyc < 30 && $urandom_range(0, 4) == 0;
        end
        start = 0;
        chk("first_valid_cycle", first_v, 2);
        chk("beat_count", got_d.size(), NB);
        for (int i = 0; i < NB && i < got_d.size(); i++) begin
            chk($sformatf("beat%0d_data", i), got_d[i], exp_d[i]);
            chk($sformatf("beat%0d_last", i), got_l[i], (i == NB - 1));
        end
        chk("read_count", rd_q.size(), W * W);
        for (int i = 0; i < rd_q.size() && i < W * W; i++)
            chk($sformatf("rd_addr%0d", i), rd_q[i], i);
        chk("done_after_last", done_cyc, (last_acc < 0) ? -2 : last_acc + 1);
        chk("stall_hold", stall_bad, 0);
        repeat (3) @(negedge clk);
        chk("idle_after_frame", {busy, valid_out, done}, 3'b000);
    endtask

    initial begin
        int n, cyc, beats, reads, errs, done_cyc;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_en", mem_rd_en, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_valid", valid_out, 0);
        chk("rst_data", data_out, 0);
        chk("rst_last", last_out, 0);
        @(posedge clk); #1 rst = 0;

        for (int i = 0; i < 16; i++) mem[i] = 8'(i + 1);
        build_expected();
        run_frame(0, 0);
        run_frame(1, 0);
        run_frame(2, 0);
        run_frame(0, 1);
        run_frame(0, 0);
        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom_range(1, 255));
        build_expected();
        run_frame(1, 1);

        // Reset in the middle of a frame
        @(posedge clk); #1 start = 1; ready = 1;
        @(posedge clk); #1 start = 0;
        n = 0; cyc = 0;
        while (n < 20 && cyc < 200) begin
            @(negedge clk);
            if (valid_out && ready) n++;
            cyc++;
        end
        chk("pre_reset_accepts", n, 20);
        #1 rst = 1;
        #1;
        chk("midrst_valid", valid_out, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_rd_en", mem_rd_en, 0);
        errs = 0;
        repeat (3) begin
            @(negedge clk);
            if (done || valid_out) errs++;
        end
        @(posedge clk); #1 rst = 0;
        repeat (2) @(negedge clk);
        if (done || busy) errs++;
        chk("midrst_no_done", errs, 0);
        run_frame(0, 0);

        // Default-size frame with ready held high
        @(posedge clk); #1 b_start = 1;
        @(posedge clk); #1 b_start = 0;
        beats = 0; reads = 0; errs = 0; done_cyc = -1;
        for (int c = 0; c < 17100; c++) begin
            @(negedge clk);
            if (b_rd_en) reads++;
            if (b_valid) begin
                int r, k;
                logic [7:0] e;
                r = beats / 130;
                k = beats % 130;
                e = (r >= 1 && r <= 128 && k >= 1 && k <= 128) ? (8'((r-1)*128 + (k-1)) ^ 8'h5A) : 8'h00;
                if (b_data !== e || b_last !== (beats == 16899)) errs++;
                beats++;
            end
            if (b_done) begin
                done_cyc = c;
                break;
            end
        end
        chk("big_beats", beats, 16900);
        chk("big_reads", reads, 16384);
        chk("big_data_errs", errs, 0);
        chk("big_done_in_time", (done_cyc >= 0 && done_cyc <= 16900 + 3), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
